// File: rtl/triangle_raster_scan_pkg.sv
// Shared types for the triangle rasterizer: vertex/triangle structs, fill latency
// and the coordinate tag carried alongside the fill pipeline.
package triangle_raster_scan_pkg;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } vec3_i16;

  typedef struct packed {
    vec3_i16 v0;
    vec3_i16 v1;
    vec3_i16 v2;
  } tri_2d;

  localparam int unsigned FILL_LATENCY_C = 3;
  localparam int unsigned COORD_W        = 12;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
    logic   last;
  } tag_t;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/triangle_raster_scan_if.sv
// Triangle-in / pixel-out bundle of the rasterizer; slave is the rasterizer side.
interface triangle_raster_scan_if;
  import triangle_raster_scan_pkg::*;

  logic   tri_valid;
  logic   tri_ready;
  tri_2d  triangle;
  logic   px_valid;
  coord_t px_x;
  coord_t px_y;
  logic   done;
  logic   busy;

  modport slave (
    input  tri_valid, triangle,
    output tri_ready, px_valid, px_x, px_y, done, busy
  );

  modport master (
    output tri_valid, triangle,
    input  tri_ready, px_valid, px_x, px_y, done, busy
  );

endinterface

// File: rtl/triangle_raster_scan_fill.sv
// Edge-function coverage test: is_within is valid FILL_LATENCY_C cycles after
// hcount/vcount; a point is inside when no two edge values have opposite signs.
module triangle_2d_fill
  import triangle_raster_scan_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  tri_2d  triangle,
  input  coord_t hcount,
  input  coord_t vcount,
  output logic   is_within
);

  coord_t vx [3];
  coord_t vy [3];

  logic signed [12:0] ex_q [3];
  logic signed [12:0] ey_q [3];
  logic signed [12:0] dx_q [3];
  logic signed [12:0] dy_q [3];
  logic signed [25:0] p1_q [3];
  logic signed [25:0] p2_q [3];
  logic signed [26:0] e    [3];
  logic               any_neg;
  logic               any_pos;
  logic               unused_bits;

  always_comb begin
    vx[0] = triangle.v0.x[11:0];
    vy[0] = triangle.v0.y[11:0];
    vx[1] = triangle.v1.x[11:0];
    vy[1] = triangle.v1.y[11:0];
    vx[2] = triangle.v2.x[11:0];
    vy[2] = triangle.v2.y[11:0];
  end

  assign unused_bits = ^{triangle.v0.x[15:12], triangle.v0.y[15:12], triangle.v0.z,
                         triangle.v1.x[15:12], triangle.v1.y[15:12], triangle.v1.z,
                         triangle.v2.x[15:12], triangle.v2.y[15:12], triangle.v2.z};

  // Edge i runs from vertex i to vertex (i+1)%3; e = ex*(py-ay) - ey*(px-ax)
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      ex_q[i] <= $signed({1'b0, vx[(i+1)%3]}) - $signed({1'b0, vx[i]});
      ey_q[i] <= $signed({1'b0, vy[(i+1)%3]}) - $signed({1'b0, vy[i]});
      dx_q[i] <= $signed({1'b0, hcount}) - $signed({1'b0, vx[i]});
      dy_q[i] <= $signed({1'b0, vcount}) - $signed({1'b0, vy[i]});
      p1_q[i] <= ex_q[i] * dy_q[i];
      p2_q[i] <= ey_q[i] * dx_q[i];
    end
  end

  always_comb begin
    any_neg = 1'b0;
    any_pos = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      e[i]    = $signed({p1_q[i][25], p1_q[i]}) - $signed({p2_q[i][25], p2_q[i]});
      any_neg = any_neg | e[i][26];
      any_pos = any_pos | (!e[i][26] && (e[i] != '0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) is_within <= 1'b0;
    else     is_within <= !(any_neg && any_pos);
  end

endmodule

// File: rtl/triangle_raster_scan.sv
// Bounding-box rasterizer: clips the triangle's box to the screen, scans it in
// raster order through triangle_2d_fill and emits the covered pixels.
module triangle_raster_scan
  import triangle_raster_scan_pkg::*;
#(
  parameter int unsigned SCREEN_W     = 1280,
  parameter int unsigned SCREEN_H     = 720,
  parameter int unsigned FILL_LATENCY = FILL_LATENCY_C
)(
  input logic                  clk,
  input logic                  rst,
  triangle_raster_scan_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam coord_t X_LAST = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_LAST = coord_t'(SCREEN_H - 1);

  logic [1:0] state_q, state_d;
  tri_2d      tri_q, tri_d;
  coord_t     xmin_q, xmin_d, xmax_q, xmax_d;
  coord_t     ymin_q, ymin_d, ymax_q, ymax_d;
  coord_t     hcount_q, hcount_d, vcount_q, vcount_d;
  tag_t       tag_q [FILL_LATENCY];
  tag_t       tag_in;
  logic       px_valid_q;
  coord_t     px_x_q, px_y_q;
  logic       done_q;
  logic       empty_done;

  coord_t     bx_min, bx_max_raw, bx_max;
  coord_t     by_min, by_max_raw, by_max;
  logic       box_empty;
  logic       last_pt;
  logic       is_within;

  always_comb begin
    bx_min     = min3(tri_q.v0.x[11:0], tri_q.v1.x[11:0], tri_q.v2.x[11:0]);
    bx_max_raw = max3(tri_q.v0.x[11:0], tri_q.v1.x[11:0], tri_q.v2.x[11:0]);
    by_min     = min3(tri_q.v0.y[11:0], tri_q.v1.y[11:0], tri_q.v2.y[11:0]);
    by_max_raw = max3(tri_q.v0.y[11:0], tri_q.v1.y[11:0], tri_q.v2.y[11:0]);
    bx_max     = (bx_max_raw > X_LAST) ? X_LAST : bx_max_raw;
    by_max     = (by_max_raw > Y_LAST) ? Y_LAST : by_max_raw;
    box_empty  = (bx_min > X_LAST) || (by_min > Y_LAST);
  end

  assign last_pt = (state_q == ST_SCAN) && (hcount_q == xmax_q) && (vcount_q == ymax_q);

  always_comb begin
    state_d    = state_q;
    tri_d      = tri_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymin_d     = ymin_q;
    ymax_d     = ymax_q;
    hcount_d   = hcount_q;
    vcount_d   = vcount_q;
    empty_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.tri_valid) begin
          tri_d   = bus.triangle;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        xmin_d = bx_min;
        xmax_d = bx_max;
        ymin_d = by_min;
        ymax_d = by_max;
        if (box_empty) begin
          // Empty box shares DRAIN so tri_ready stays low during the done pulse
          empty_done = 1'b1;
          state_d    = ST_DRAIN;
        end else begin
          hcount_d = bx_min;
          vcount_d = by_min;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hcount_q == xmax_q) begin
          hcount_d = xmin_q;
          vcount_d = coord_t'(vcount_q + 1'b1);
        end else begin
          hcount_d = coord_t'(hcount_q + 1'b1);
        end
        if (last_pt) state_d = ST_DRAIN;
      end
      default: begin
        if (done_q) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
    tri_q    <= tri_d;
    xmin_q   <= xmin_d;
    xmax_q   <= xmax_d;
    ymin_q   <= ymin_d;
    ymax_q   <= ymax_d;
    hcount_q <= hcount_d;
    vcount_q <= vcount_d;
  end

  triangle_2d_fill u_fill (
    .clk       (clk),
    .rst       (rst),
    .triangle  (tri_q),
    .hcount    (hcount_q),
    .vcount    (vcount_q),
    .is_within (is_within)
  );

  assign tag_in = '{valid: (state_q == ST_SCAN), x: hcount_q, y: vcount_q, last: last_pt};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FILL_LATENCY; i++) tag_q[i] <= '0;
      px_valid_q <= 1'b0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < FILL_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      px_valid_q <= tag_q[FILL_LATENCY-1].valid & is_within;
      px_x_q     <= tag_q[FILL_LATENCY-1].x;
      px_y_q     <= tag_q[FILL_LATENCY-1].y;
      done_q     <= tag_q[FILL_LATENCY-1].last | empty_done;
    end
  end

  assign bus.tri_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.px_valid  = px_valid_q;
  assign bus.px_x      = px_x_q;
  assign bus.px_y      = px_y_q;
  assign bus.done      = done_q;

endmodule

// File: doc/triangle_raster_scan.md
# triangle_raster_scan

Bounding-box rasterizer that sits around `triangle_2d_fill`. It accepts one screen-space `tri_2d` per handshake, computes its screen-clipped bounding box, and scans every pixel of the box in raster order into `triangle_2d_fill`. Each scanned coordinate is carried through a tag pipeline matched to the fill latency, so the block emits exactly the covered pixels to the downstream fragment/framebuffer write stage.

## Interface
- `SCREEN_W`, default 1280: horizontal resolution; x is clipped to `0..SCREEN_W-1`.
- `SCREEN_H`, default 720: vertical resolution; y is clipped to `0..SCREEN_H-1`.
- `FILL_LATENCY`, default 3: cycles from `hcount`/`vcount` presented to `is_within` valid in `triangle_2d_fill`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `tri_valid` in 1: a triangle is offered.
- `tri_ready` out 1: the block is idle and can accept a triangle.
- `triangle` in `tri_2d`: three vertices; only bits [11:0] of x and y are used, as unsigned values.
- `px_valid` out 1: a covered pixel is present this cycle.
- `px_x` out 12: pixel x.
- `px_y` out 12: pixel y.
- `done` out 1: one-cycle pulse marking the end of the current triangle.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Handshake:** a triangle is accepted when `tri_valid & tri_ready` is true at a clock edge. The triangle is latched into a register, and that register drives `triangle_2d_fill` for the whole job. There is no output backpressure; the downstream stage accepts every `px_valid`.
- **IDLE:** `tri_ready=1`. On accept, go to SETUP.
- **SETUP (1 cycle):**
  - Compute `xmin`, `xmax`, `ymin`, `ymax` as the unsigned min/max of the vertices.
  - Clip `xmax` to `SCREEN_W-1` and `ymax` to `SCREEN_H-1`.
  - If `xmin > SCREEN_W-1` or `ymin > SCREEN_H-1`, the box is empty: pulse `done` and return to IDLE.
  - Otherwise load `hcount=xmin`, `vcount=ymin` and go to SCAN.
- **SCAN:**
  - Issue one point per cycle, with x varying fastest.
  - At `hcount==xmax`: set `hcount=xmin` and increment `vcount`.
  - At `hcount==xmax` and `vcount==ymax`: this is the last point. Tag it `last` and go to DRAIN.
- **DRAIN:** wait until the `last` tag reaches the output. In that cycle pulse `done`, then go to IDLE.
- **Tag pipeline:** a shift register of `{valid, x, y, last}`, depth `FILL_LATENCY`, advancing every cycle. Outputs are registered:
  - `px_valid <= tag_valid & is_within`
  - `px_x`/`px_y` take the tag coordinates
  - `done <= tag_last`
- **Degenerate triangles:** behaviour follows `is_within`. For three identical vertices, all signs are zero, so exactly one pixel is emitted. Collinear vertices emit the segment pixels for which all signs are zero or same-signed.
- **Coordinate range:** vertices are in the range 0..4095. Negative inputs are out of scope; they alias to large values and get clipped.

## Timing
- Accept at cycle 0. SETUP runs in cycle 1. Box point k (k=0..N-1, N=box width×height) is issued in cycle 2+k.
- The output for point k appears in cycle 2+k+FILL_LATENCY+1, which is 6+k at the defaults.
- `done` pulses in cycle N+5 at the defaults. For an empty box it pulses in cycle 2.
- `tri_ready` returns high in the cycle after `done`. The minimum interval between triangles is therefore N+6 cycles.
- **Reset values:**
  - `tri_ready=1`, `busy=0`, `px_valid=0`, `px_x=0`, `px_y=0`, `done=0`.
  - State is IDLE and all tag valids are cleared.
  - The same `rst` drives `triangle_2d_fill`.
- **Reset mid-operation:** the job is discarded and no further `px_valid` or `done` is produced. `tri_ready=1` in the first cycle with `rst` low.
- **`tri_valid` while busy:** the offer is ignored (not accepted) and must be held until `tri_ready` is high.
- **Simultaneous `done` and `tri_valid`:** not accepted that cycle, because `tri_ready` is still 0.

## Structure
- The shared package holds the existing `vec3_i16` and `tri_2d`, plus `FILL_LATENCY_C=3`, referenced by both this block and `triangle_2d_fill`.
- Instantiate `triangle_2d_fill` as the single sub-module. The bounding-box min/max/clip logic is inline combinational logic feeding the SETUP register.

## Test plan
1. **Reset:** drive `rst` for 2 cycles. Expect `tri_ready=1`, `busy=0`, `px_valid=0`, `done=0`.
2. **Small right triangle:** vertices (0,0),(3,0),(0,3). Expect a 4×4 box (N=16) and exactly 10 pixels, those with x+y≤3, in raster order. The first pixel (0,0) appears at cycle 6. `done` pulses at cycle 21.
3. **Point triangle:** all three vertices at (5,5). Expect exactly one pixel (5,5) at cycle 6, and `done` at cycle 6.
4. **Right/bottom-edge clip:** vertices (1270,710),(1300,710),(1270,740). Every emitted pixel has x in 1270..1279 and y in 710..719. The box is 10×10, so `done` pulses at cycle 105.
5. **Off-screen:** all vertices at x=2000. Expect no `px_valid`, `done` at cycle 2, and `tri_ready=1` at cycle 3.
6. **Reset mid-scan:** assert `rst` at cycle 8 of the test-2 triangle. Expect no `px_valid` and no `done` after cycle 8. `tri_ready=1` in the first cycle after release. A second triangle then rasterizes correctly.
